// File: rtl/fmeasure_counter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over a window
// of GATE_CYCLES clk cycles and publishes each completed count with a valid pulse.
module fmeasure_counter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sig_in,
  input  logic        enable,
  output logic [31:0] freq_count,
  output logic        freq_valid,
  output logic        overflow
);

  localparam int                 GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE
  } state_t;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 delayed_q;
  logic                 edge_det;
  logic [GATE_W-1:0]    gate_cnt, gate_cnt_next;
  logic [COUNT_W-1:0]   edge_cnt, edge_cnt_next;
  logic [COUNT_W-1:0]   count_q, count_next;
  logic [COUNT_W-1:0]   edge_total;
  logic                 sat, sat_next, sat_total;
  logic                 overflow_next, valid_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      delayed_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~delayed_q;

  // Count this cycle's edge, saturating at the top of the counter range.
  always_comb begin
    edge_total = edge_cnt;
    sat_total  = sat;
    if (edge_det) begin
      if (edge_cnt == CNT_MAX) sat_total = 1'b1;
      else                     edge_total = edge_cnt + COUNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state;
    gate_cnt_next = gate_cnt;
    edge_cnt_next = edge_cnt;
    sat_next      = sat;
    count_next    = count_q;
    overflow_next = overflow;
    valid_next    = 1'b0;
    case (state)
      IDLE: begin
        gate_cnt_next = '0;
        edge_cnt_next = '0;
        sat_next      = 1'b0;
        if (enable) state_next = ARM;
      end
      ARM: begin
        gate_cnt_next = '0;
        edge_cnt_next = '0;
        sat_next      = 1'b0;
        state_next    = GATE;
      end
      GATE: begin
        if (gate_cnt == GATE_LAST) begin
          count_next    = edge_total;
          overflow_next = sat_total;
          valid_next    = 1'b1;
          gate_cnt_next = '0;
          edge_cnt_next = '0;
          sat_next      = 1'b0;
          state_next    = enable ? GATE : IDLE;
        end else if (!enable) begin
          // Abort: the partial count is dropped, the last result stays visible.
          gate_cnt_next = '0;
          edge_cnt_next = '0;
          sat_next      = 1'b0;
          state_next    = IDLE;
        end else begin
          gate_cnt_next = gate_cnt + GATE_W'(1);
          edge_cnt_next = edge_total;
          sat_next      = sat_total;
        end
      end
      default: begin
        gate_cnt_next = '0;
        edge_cnt_next = '0;
        sat_next      = 1'b0;
        state_next    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      count_q    <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      state      <= state_next;
      gate_cnt   <= gate_cnt_next;
      edge_cnt   <= edge_cnt_next;
      sat        <= sat_next;
      count_q    <= count_next;
      overflow   <= overflow_next;
      freq_valid <= valid_next;
    end
  end

  assign freq_count = 32'(count_q);

endmodule

// File: tb/tb_fmeasure_counter.sv
// Bench for fmeasure_counter: a 32-bit and a 4-bit instance share stimulus and are
// checked every cycle against a window-level edge-counting model.
module tb_fmeasure_counter;

  localparam int GATE = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sig_in = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] fc32, fc4;
  logic        fv32, fv4, ov32, ov4;

  int errors = 0;
  int checks = 0;

  int  period = 3;
  int  phase = 0;
  bit  static_level = 1'b0;
  bit  rand_sig = 1'b0;

  always #5 clk = ~clk;

  fmeasure_counter #(.GATE_CYCLES(GATE), .COUNT_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
    .freq_count(fc32), .freq_valid(fv32), .overflow(ov32)
  );

  fmeasure_counter #(.GATE_CYCLES(GATE), .COUNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
    .freq_count(fc4), .freq_valid(fv4), .overflow(ov4)
  );

  // Signal source: periodic square wave, per-cycle random bits, or a static level.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rand_sig) sig_in = 1'($urandom_range(0, 1));
      else if (period > 0) begin
        phase++;
        if (phase >= period) phase = 0;
        sig_in = (phase < period / 2);
      end else sig_in = static_level;
    end
  end

  // Model: a window is a run of GATE consecutive counting clock edges; an edge on
  // sig_in sampled at clock k is counted at clock k+2 or k+3 (synchroniser latency).
  bit          p1 = 0, p2 = 0, p3 = 0, e_now = 0;
  bit          active = 0;
  longint      cyc = 0, win_start = 0;
  int unsigned m_cnt = 0;
  logic [31:0] exp_count32 = 0, exp_count4 = 0;
  bit          exp_ov4 = 0, exp_valid = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        p1 = 0; p2 = 0; p3 = 0;
        active = 0; m_cnt = 0;
        exp_count32 = 0; exp_count4 = 0; exp_ov4 = 0; exp_valid = 0;
      end else begin
        e_now = p2 & ~p3;
        exp_valid = 0;
        if (active) begin
          if (cyc >= win_start) begin
            if (e_now) m_cnt++;
            if (cyc == win_start + GATE - 1) begin
              exp_count32 = m_cnt;
              exp_count4  = (m_cnt > 15) ? 32'd15 : m_cnt;
              exp_ov4     = (m_cnt > 15);
              exp_valid   = 1;
              m_cnt = 0;
              if (enable) win_start = cyc + 1;
              else active = 0;
            end else if (!enable) begin
              active = 0;
              m_cnt = 0;
            end
          end
        end else if (enable) begin
          active = 1;
          win_start = cyc + 2;
          m_cnt = 0;
        end
        p3 = p2; p2 = p1; p1 = sig_in;
        cyc++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    @(negedge reset_n);
    forever begin
      @(negedge clk);
      checkOutput("count32", fc32, exp_count32);
      checkOutput("valid32", 32'(fv32), 32'(exp_valid));
      checkOutput("ovf32", 32'(ov32), 32'd0);
      checkOutput("count4", fc4, exp_count4);
      checkOutput("valid4", 32'(fv4), 32'(exp_valid));
      checkOutput("ovf4", 32'(ov4), 32'(exp_ov4));
    end
  end

  task automatic applyStimulus(input bit en, input int per, input bit lvl,
                               input bit rnd, input bit rst_n);
    @(negedge clk);
    #1;
    enable = en;
    period = per;
    static_level = lvl;
    rand_sig = rnd;
    reset_n = rst_n;
  endtask

  task automatic waitValid(output int cycles);
    bit ok;
    ok = 0;
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cycles++;
      if (fv32) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: actual=no pulse in %0d cycles required=pulse", cycles);
    end
  endtask

  int gap, pulses;

  initial begin
    #1 reset_n = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("reset_count", fc32, 32'd0);
    checkOutput("reset_valid", 32'(fv32), 32'd0);
    checkOutput("reset_ovf", 32'(ov4), 32'd0);

    $display("[TB] period 10 continuous");
    applyStimulus(1, 10, 0, 0, 1);
    waitValid(gap);
    waitValid(gap);
    checkOutput("p10_gap", gap, 32'd100);
    checkOutput("p10_count", fc32, 32'd10);

    $display("[TB] period 4 back-to-back, 4-bit saturation");
    applyStimulus(1, 4, 0, 0, 1);
    waitValid(gap);
    waitValid(gap);
    checkOutput("p4_gap", gap, 32'd100);
    checkOutput("p4_count", fc32, 32'd25);
    checkOutput("p4_count4", fc4, 32'd15);
    checkOutput("p4_ovf4", 32'(ov4), 32'd1);
    waitValid(gap);
    checkOutput("p4_gap2", gap, 32'd100);
    checkOutput("p4_count2", fc32, 32'd25);

    applyStimulus(1, 10, 0, 0, 1);
    waitValid(gap);
    waitValid(gap);
    checkOutput("p10_count4", fc4, 32'd10);
    checkOutput("p10_ovf4", 32'(ov4), 32'd0);

    $display("[TB] abort mid-window and re-enable");
    waitValid(gap);
    repeat (49) @(negedge clk);
    applyStimulus(0, 10, 0, 0, 1);
    pulses = 0;
    repeat (150) begin
      @(negedge clk);
      if (fv32) pulses++;
    end
    checkOutput("abort_pulses", pulses, 32'd0);
    checkOutput("abort_hold", fc32, 32'd10);
    applyStimulus(1, 10, 0, 0, 1);
    waitValid(gap);
    checkOutput("reenable_latency", gap, 32'd102);

    $display("[TB] stale edge at enable");
    applyStimulus(0, 0, 0, 0, 1);
    repeat (10) @(negedge clk);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    waitValid(gap);
    checkOutput("stale_latency", gap, 32'd102);
    checkOutput("stale_count", fc32, 32'd0);

    $display("[TB] randomized run");
    for (int it = 0; it < 40; it++) begin
      bit rnd, en;
      int per;
      rnd = ($urandom_range(0, 2) == 0);
      per = $urandom_range(3, 12);
      en  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(en, per, 0, rnd, 0);
        repeat (2) @(negedge clk);
      end
      applyStimulus(en, per, 0, rnd, 1);
      repeat ($urandom_range(5, 250)) @(negedge clk);
    end

    applyStimulus(0, 0, 0, 0, 1);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
